mtm_serial_rx: RTL and testbench

MTM_SERIAL_RX -- requirements
Module: mtm_serial_rx

---
 rtl/mtm_serial_rx.sv | 150 +++++++++++++++
 tb/tb_mtm_serial_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_serial_rx.sv
// Serial packet receiver: 11-bit frames carry two operands and a command byte.
// A CRC-4 guards the packet; results wait in a held output register.
module mtm_serial_rx #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [2:0]        op_out,
    output logic [2:0]        err_out,
    output logic              overrun
);

    localparam int NB = DATA_W / 8;
    localparam int NF = 2 * NB;
    localparam int CW = $clog2(NF + 2);
    localparam logic [CW-1:0] NF_C  = CW'(NF);
    localparam logic [CW-1:0] SAT_C = CW'(NF + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_PAY,
        S_STOP
    } state_t;

    state_t state, state_nx;

    logic [2:0]          bit_cnt;
    logic                is_cmd;
    logic [7:0]          pay;
    logic [CW-1:0]       cnt;
    logic [3:0]          crc;
    logic [2*DATA_W-1:0] sr;

    logic       frame_ok;
    logic       frame_err;
    logic       data_done;
    logic       cmd_done;
    logic [2:0] cmd_op;
    logic [3:0] crc_exp;
    logic       err_data;
    logic       err_crc;
    logic       err_op;

    function automatic logic [3:0] crc_bit(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
        logic [3:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = crc_bit(r, d[i]);
        end
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (!sin) state_nx = S_TYPE;
            S_TYPE:  state_nx = S_PAY;
            S_PAY:   if (bit_cnt == 3'd7) state_nx = S_STOP;
            S_STOP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        frame_ok  = (state == S_STOP) && sin;
        frame_err = (state == S_STOP) && !sin;
        data_done = frame_ok && !is_cmd;
        cmd_done  = frame_ok && is_cmd;
        cmd_op    = pay[6:4];
        // The marker bit 1 precedes OP in the checked stream.
        crc_exp   = crc_bit(crc_bit(crc_bit(crc_bit(crc, 1'b1),
                    cmd_op[2]), cmd_op[1]), cmd_op[0]);
        err_data  = (cnt != NF_C);
        err_crc   = !err_data && (crc_exp != pay[3:0]);
        err_op    = !err_data && !err_crc && cmd_op[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            is_cmd  <= 1'b0;
            pay     <= '0;
            cnt     <= '0;
            crc     <= '0;
            sr      <= '0;
        end else begin
            if (state == S_TYPE) begin
                is_cmd  <= sin;
                bit_cnt <= '0;
            end
            if (state == S_PAY) begin
                pay     <= {pay[6:0], sin};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (frame_err || cmd_done) begin
                cnt <= '0;
                crc <= '0;
            end else if (data_done) begin
                if (cnt < NF_C) begin
                    sr  <= {sr[2*DATA_W-9:0], pay};
                    crc <= crc_byte(crc, pay);
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt <= SAT_C;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
            err_out   <= '0;
            overrun   <= 1'b0;
        end else if (cmd_done && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            a_out     <= err_data ? '0 : sr[DATA_W-1:0];
            b_out     <= err_data ? '0 : sr[2*DATA_W-1:DATA_W];
            op_out    <= cmd_op;
            err_out   <= {err_data, err_crc, err_op};
        end else begin
            if (cmd_done) overrun <= 1'b1;
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mtm_serial_rx.sv
// Testbench for mtm_serial_rx: directed and random packets checked
// against a polynomial-division CRC model and an expected-result queue.
module tb_mtm_serial_rx;

    localparam int W  = 32;
    localparam int NB = W / 8;
    localparam int NF = 2 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [2:0]   op_out;
    logic [2:0]   err_out;
    logic         overrun;

    always #5 clk = ~clk;

    mtm_serial_rx #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .op_out    (op_out),
        .err_out   (err_out),
        .overrun   (overrun)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [2:0]   err;
    } res_t;

    res_t expq[$];
    res_t gotq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vcyc = 0;
    int   vbase = 0;
    int   grd = 0;
    int   erd = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) vcyc++;
            if (out_valid && out_ready)
                gotq.push_back('{a: a_out, b: b_out, op: op_out, err: err_out});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC as the remainder of msg*x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [W-1:0] b, input logic [W-1:0] a,
                                           input logic [2:0] op);
        logic [2*W+7:0] m;
        m = {b, a, 1'b1, op, 4'b0000};
        for (int i = 2*W+7; i >= 4; i--) begin
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        end
        return m[3:0];
    endfunction

    function automatic res_t make_exp(input int nd, input logic [W-1:0] b, input logic [W-1:0] a,
                                      input logic [2:0] op, input logic [3:0] crcx);
        res_t r;
        r.op = op;
        if (nd != NF) begin
            r.a = '0;
            r.b = '0;
            r.err = 3'b100;
        end else begin
            r.a = a;
            r.b = b;
            if (crcx != 4'd0) r.err = 3'b010;
            else if (op == 3'b010 || op == 3'b011 || op == 3'b110 || op == 3'b111) r.err = 3'b001;
            else r.err = 3'b000;
        end
        return r;
    endfunction

    task automatic send_bit(input logic v);
        sin = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] p, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(p[i]);
        send_bit(stop);
    endtask

    task automatic send_data(input int nd, input logic [W-1:0] b, input logic [W-1:0] a);
        logic [2*W-1:0] s;
        logic [7:0]     byt;
        s = {b, a};
        for (int j = 0; j < nd; j++) begin
            if (j < NF) byt = s[2*W-1-8*j -: 8];
            else byt = 8'($urandom);
            send_frame(1'b0, byt, 1'b1);
        end
    endtask

    task automatic send_packet(input int nd, input logic [W-1:0] b, input logic [W-1:0] a,
                               input logic [2:0] op, input logic [3:0] crcx);
        send_data(nd, b, a);
        send_frame(1'b1, {1'b0, op, ref_crc(b, a, op) ^ crcx}, 1'b1);
    endtask

    task automatic check_results(input string tag, input logic pulses);
        int ng;
        int ne;
        res_t g;
        res_t e;
        sin = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ng = gotq.size() - grd;
        ne = expq.size() - erd;
        check({tag, "_count"}, 64'(ng), 64'(ne));
        for (int i = 0; i < ne && i < ng; i++) begin
            g = gotq[grd+i];
            e = expq[erd+i];
            check({tag, "_a"}, 64'(g.a), 64'(e.a));
            check({tag, "_b"}, 64'(g.b), 64'(e.b));
            check({tag, "_op"}, 64'(g.op), 64'(e.op));
            check({tag, "_err"}, 64'(g.err), 64'(e.err));
        end
        if (pulses) check({tag, "_pulses"}, 64'(vcyc - vbase), 64'(ne));
        vbase = vcyc;
        grd = gotq.size();
        erd = expq.size();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] b;
        logic [W-1:0] a;
        logic [2:0]   op;
        logic [3:0]   cx;
        int           nd;
        int           mode;
        res_t         first;

        rst = 1'b1;
        sin = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_a", 64'(a_out), 64'd0);
        check("rst_b", 64'(b_out), 64'd0);
        check("rst_op", 64'(op_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        rst = 1'b0;
        repeat (3) send_bit(1'b1);

        expq.push_back(make_exp(NF, 32'h11, 32'h15, 3'b100, 4'd0));
        send_packet(NF, 32'h11, 32'h15, 3'b100, 4'd0);
        check_results("good", 1'b1);

        expq.push_back(make_exp(NF, 32'h11, 32'h15, 3'b100, 4'd1));
        send_packet(NF, 32'h11, 32'h15, 3'b100, 4'd1);
        check_results("crcbad", 1'b1);

        expq.push_back(make_exp(NF-1, 32'h1234, 32'h5678, 3'b001, 4'd0));
        send_packet(NF-1, 32'h1234, 32'h5678, 3'b001, 4'd0);
        expq.push_back(make_exp(NF, 32'hcafe0001, 32'hbeef0002, 3'b101, 4'd0));
        send_packet(NF, 32'hcafe0001, 32'hbeef0002, 3'b101, 4'd0);
        check_results("short", 1'b1);

        expq.push_back(make_exp(0, 32'h0, 32'h0, 3'b000, 4'd0));
        send_packet(0, 32'h0, 32'h0, 3'b000, 4'd0);
        check_results("cmdfirst", 1'b1);

        expq.push_back(make_exp(NF, 32'hdeadbeef, 32'h01020304, 3'b111, 4'd0));
        send_packet(NF, 32'hdeadbeef, 32'h01020304, 3'b111, 4'd0);
        check_results("badop", 1'b1);

        expq.push_back(make_exp(NF+2, 32'h0f0f0f0f, 32'hf0f0f0f0, 3'b000, 4'd0));
        send_packet(NF+2, 32'h0f0f0f0f, 32'hf0f0f0f0, 3'b000, 4'd0);
        check_results("long", 1'b1);

        send_frame(1'b0, 8'haa, 1'b1);
        send_frame(1'b0, 8'h55, 1'b1);
        send_frame(1'b0, 8'h3c, 1'b0);
        expq.push_back(make_exp(NF, 32'h89abcdef, 32'h76543210, 3'b100, 4'd0));
        send_packet(NF, 32'h89abcdef, 32'h76543210, 3'b100, 4'd0);
        check_results("stoperr", 1'b1);

        send_data(NF, 32'h1, 32'h2);
        send_frame(1'b1, {1'b0, 3'b000, ref_crc(32'h1, 32'h2, 3'b000)}, 1'b0);
        expq.push_back(make_exp(NF, 32'h3, 32'h4, 3'b001, 4'd0));
        send_packet(NF, 32'h3, 32'h4, 3'b001, 4'd0);
        check_results("cmdstop", 1'b1);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        pulse_rst();
        repeat (12) send_bit(1'b1);
        check_results("rstpay", 1'b1);

        send_data(3, 32'h77777777, 32'h88888888);
        pulse_rst();
        repeat (3) send_bit(1'b1);
        expq.push_back(make_exp(NF, 32'h13572468, 32'h24681357, 3'b000, 4'd0));
        send_packet(NF, 32'h13572468, 32'h24681357, 3'b000, 4'd0);
        check_results("rstpkt", 1'b1);

        for (int k = 0; k < 12; k++) begin
            mode = $urandom_range(0, 2);
            b = W'($urandom);
            a = W'($urandom);
            op = 3'($urandom_range(0, 7));
            nd = (mode == 2) ? $urandom_range(0, NF + 2) : NF;
            cx = (mode == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            expq.push_back(make_exp(nd, b, a, op, cx));
            send_packet(nd, b, a, op, cx);
            check_results("rnd", 1'b1);
        end

        out_ready = 1'b0;
        first = make_exp(NF, 32'haaaa5555, 32'h5555aaaa, 3'b100, 4'd0);
        send_packet(NF, 32'haaaa5555, 32'h5555aaaa, 3'b100, 4'd0);
        repeat (2) send_bit(1'b1);
        check("hold1_valid", 64'(out_valid), 64'd1);
        check("hold1_ovr", 64'(overrun), 64'd0);
        send_packet(NF, 32'h11111111, 32'h22222222, 3'b001, 4'd0);
        repeat (2) send_bit(1'b1);
        check("hold2_valid", 64'(out_valid), 64'd1);
        check("hold2_a", 64'(a_out), 64'(first.a));
        check("hold2_b", 64'(b_out), 64'(first.b));
        check("hold2_op", 64'(op_out), 64'(first.op));
        check("hold2_err", 64'(err_out), 64'(first.err));
        check("hold2_ovr", 64'(overrun), 64'd1);
        pulse_rst();
        check("ovrrst_ovr", 64'(overrun), 64'd0);
        check("ovrrst_valid", 64'(out_valid), 64'd0);
        check("ovrrst_a", 64'(a_out), 64'd0);
        out_ready = 1'b1;
        check_results("ovrq", 1'b0);

        expq.push_back(make_exp(NF, 32'h00000000, 32'hffffffff, 3'b101, 4'd0));
        send_packet(NF, 32'h00000000, 32'hffffffff, 3'b101, 4'd0);
        check_results("after", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
